// File: rtl/hls_deadlock_report_ctrl.sv
// Supervisory controller over per-instance HLS deadlock monitors: round-robin scan,
// persistence qualification, and one-at-a-time sticky reporting with ack and hold-off.
module hls_deadlock_report_ctrl #(
  parameter int NUM_MON = 4,
  parameter int IDX_W   = 2,
  parameter int THRESH  = 4,
  parameter int CNT_W   = 8,
  parameter int HOLDOFF = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic [NUM_MON-1:0] mon_block,
  input  logic               ack,
  output logic               deadlock,
  output logic [IDX_W-1:0]   deadlock_idx,
  output logic               busy,
  output logic [15:0]        report_cnt,
  output logic [2:0]         state_dbg
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SCAN    = 3'd1,
    CONFIRM = 3'd2,
    REPORT  = 3'd3,
    HOLDOFF_ST = 3'd4
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] cand;
  logic [CNT_W-1:0] cnt;

  logic             scan_hit;
  logic [IDX_W-1:0] scan_idx;
  logic [IDX_W-1:0] probe;
  logic [IDX_W-1:0] cand_next;
  logic [CNT_W-1:0] cnt_inc;
  logic [15:0]      rc_inc;

  assign state_dbg = state;
  assign cnt_inc   = cnt + CNT_W'(1);
  assign rc_inc    = (report_cnt == 16'hFFFF) ? report_cnt : report_cnt + 16'd1;
  assign cand_next = (cand == IDX_W'(NUM_MON - 1)) ? '0 : cand + IDX_W'(1);

  // Walk from the highest offset down so the last hit written is the one nearest ptr.
  always_comb begin
    scan_hit = 1'b0;
    scan_idx = '0;
    probe    = '0;
    for (int i = NUM_MON - 1; i >= 0; i--) begin
      probe = IDX_W'((int'(ptr) + i) % NUM_MON);
      if (mon_block[probe]) begin
        scan_hit = 1'b1;
        scan_idx = probe;
      end
    end
  end

  // Report handshake: deadlock rises on REPORT entry and stays high until an ack
  // pulse is sampled in REPORT; ack at any other time (including the entry edge) is dropped.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      ptr          <= '0;
      cand         <= '0;
      cnt          <= '0;
      deadlock     <= 1'b0;
      deadlock_idx <= '0;
      busy         <= 1'b0;
      report_cnt   <= '0;
    end else if (!enable) begin
      state    <= IDLE;
      deadlock <= 1'b0;
      cnt      <= '0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state <= SCAN;
          busy  <= 1'b0;
        end
        SCAN: begin
          if (scan_hit) begin
            cand <= scan_idx;
            cnt  <= CNT_W'(1);
            busy <= 1'b1;
            if (THRESH == 1) begin
              state        <= REPORT;
              deadlock     <= 1'b1;
              deadlock_idx <= scan_idx;
              report_cnt   <= rc_inc;
            end else begin
              state <= CONFIRM;
            end
          end
        end
        CONFIRM: begin
          if (mon_block[cand]) begin
            cnt <= cnt_inc;
            if (cnt_inc == CNT_W'(THRESH)) begin
              state        <= REPORT;
              deadlock     <= 1'b1;
              deadlock_idx <= cand;
              report_cnt   <= rc_inc;
            end
          end else begin
            state <= SCAN;
            busy  <= 1'b0;
            ptr   <= cand_next;
            cnt   <= '0;
          end
        end
        REPORT: begin
          if (ack) begin
            deadlock <= 1'b0;
            ptr      <= cand_next;
            cnt      <= '0;
            if (HOLDOFF == 0) begin
              state <= SCAN;
              busy  <= 1'b0;
            end else begin
              state <= HOLDOFF_ST;
            end
          end
        end
        HOLDOFF_ST: begin
          if (cnt_inc == CNT_W'(HOLDOFF)) begin
            state <= SCAN;
            busy  <= 1'b0;
            cnt   <= '0;
          end else begin
            cnt <= cnt_inc;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hls_deadlock_report_ctrl.sv
// Bench for hls_deadlock_report_ctrl: directed scenarios plus randomized traffic,
// every cycle compared against a phase/countdown reference model.
module tb_hls_deadlock_report_ctrl;

  localparam int N       = 4;
  localparam int IW      = 2;
  localparam int THR     = 4;
  localparam int HOLD    = 8;

  localparam int P_IDLE = 0, P_SCAN = 1, P_CONF = 2, P_REP = 3, P_HOLD = 4;

  logic          clock;
  logic          reset;
  logic          enable;
  logic [N-1:0]  mon_block;
  logic          ack;
  logic          deadlock;
  logic [IW-1:0] deadlock_idx;
  logic          busy;
  logic [15:0]   report_cnt;
  logic [2:0]    state_dbg;

  hls_deadlock_report_ctrl #(
    .NUM_MON(N), .IDX_W(IW), .THRESH(THR), .CNT_W(8), .HOLDOFF(HOLD)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .mon_block(mon_block), .ack(ack),
    .deadlock(deadlock), .deadlock_idx(deadlock_idx), .busy(busy),
    .report_cnt(report_cnt), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model
  int m_phase, m_ptr, m_cand, m_run, m_hold, m_idx, m_rc;
  bit m_dl;
  logic [IW-1:0] exp_q[$];
  logic prev_dl;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_phase = P_IDLE; m_ptr = 0; m_cand = 0; m_run = 0; m_hold = 0;
    m_idx = 0; m_rc = 0; m_dl = 0;
    exp_q.delete();
  endfunction

  function automatic void model_report();
    m_phase = P_REP;
    m_dl    = 1;
    m_idx   = m_cand;
    m_rc    = (m_rc < 65535) ? m_rc + 1 : 65535;
    exp_q.push_back(IW'(m_cand));
  endfunction

  function automatic void model_step(input logic en, input logic [N-1:0] mb, input logic ak);
    bit found;
    if (!en) begin
      m_phase = P_IDLE; m_dl = 0; m_run = 0;
      return;
    end
    case (m_phase)
      P_IDLE: m_phase = P_SCAN;
      P_SCAN: begin
        found = 0;
        for (int k = 0; k < N; k++) begin
          if (!found && mb[(m_ptr + k) % N]) begin
            found  = 1;
            m_cand = (m_ptr + k) % N;
          end
        end
        if (found) begin
          m_run = 1;
          if (m_run >= THR) model_report();
          else m_phase = P_CONF;
        end
      end
      P_CONF: begin
        if (mb[m_cand]) begin
          m_run++;
          if (m_run >= THR) model_report();
        end else begin
          m_phase = P_SCAN;
          m_ptr   = (m_cand + 1) % N;
        end
      end
      P_REP: begin
        if (ak) begin
          m_dl  = 0;
          m_ptr = (m_cand + 1) % N;
          if (HOLD == 0) m_phase = P_SCAN;
          else begin
            m_phase = P_HOLD;
            m_hold  = HOLD;
          end
        end
      end
      default: begin
        m_hold--;
        if (m_hold == 0) m_phase = P_SCAN;
      end
    endcase
  endfunction

  // scoreboard compare, called at the falling edge
  task automatic compare_all();
    logic exp_busy;
    exp_busy = (m_phase == P_CONF) || (m_phase == P_REP) || (m_phase == P_HOLD);
    check_val("deadlock", 32'(deadlock), 32'(m_dl));
    check_val("busy", 32'(busy), 32'(exp_busy));
    check_val("report_cnt", 32'(report_cnt), 32'(m_rc));
    if (m_dl) check_val("deadlock_idx", 32'(deadlock_idx), 32'(m_idx));
    if (deadlock && !prev_dl) begin
      check_val("rep_pending", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) check_val("rep_order", 32'(deadlock_idx), 32'(exp_q.pop_front()));
    end
    prev_dl = deadlock;
  endtask

  // driver: called at a falling edge, returns at the next falling edge
  task automatic drive_cycle(input logic en, input logic [N-1:0] mb, input logic ak);
    enable = en; mon_block = mb; ack = ak;
    @(posedge clock);
    if (reset) model_reset();
    else model_step(en, mb, ak);
    @(negedge clock);
    ack = 1'b0;
    compare_all();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive_cycle(1'b1, '1, 1'b0);
    reset = 1'b0;
  endtask

  task automatic wait_deadlock(input logic [N-1:0] mb, input int limit, output int n);
    n = 0;
    while (!deadlock && n < limit) begin
      drive_cycle(1'b1, mb, 1'b0);
      n++;
    end
    check_val("wait_deadlock", 32'(deadlock), 32'd1);
  endtask

  task automatic async_reset_pulse();
    #2 reset = 1'b1;
    #1;
    check_val("async_dl", 32'(deadlock), 32'd0);
    check_val("async_busy", 32'(busy), 32'd0);
    check_val("async_rc", 32'(report_cnt), 32'd0);
    model_reset();
    prev_dl = 1'b0;
    #1 reset = 1'b0;
  endtask

  int n;
  int exp_rr[4] = '{0, 3, 0, 3};
  logic [N-1:0] pat;
  int pat_len;

  initial begin
    reset = 1'b1; enable = 1'b1; mon_block = '1; ack = 1'b0; prev_dl = 1'b0;
    model_reset();
    @(negedge clock);

    // reset held with all monitors blocking
    for (int i = 0; i < 5; i++) drive_cycle(1'b1, 4'b1111, 1'b0);
    reset = 1'b0;
    drive_cycle(1'b1, 4'b1111, 1'b0);
    drive_cycle(1'b1, 4'b1111, 1'b0);
    check_val("scan_after_rst", 32'(busy), 32'd1);

    // confirm latency
    do_reset();
    drive_cycle(1'b1, 4'b0000, 1'b0);
    n = 0;
    while (!deadlock && n < 10) begin
      drive_cycle(1'b1, 4'b0100, 1'b0);
      n++;
    end
    check_val("latency", 32'(n), 32'd4);
    check_val("lat_idx", 32'(deadlock_idx), 32'd2);
    check_val("lat_rc", 32'(report_cnt), 32'd1);

    // glitch reject then rescan from index 2
    do_reset();
    drive_cycle(1'b1, 4'b0000, 1'b0);
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, 4'b0010, 1'b0);
    drive_cycle(1'b1, 4'b0000, 1'b0);
    check_val("glitch_dl", 32'(deadlock), 32'd0);
    wait_deadlock(4'b1111, 10, n);
    check_val("glitch_next_idx", 32'(deadlock_idx), 32'd2);

    // enable drop during report
    drive_cycle(1'b0, 4'b1111, 1'b0);
    check_val("en_drop_dl", 32'(deadlock), 32'd0);
    check_val("en_drop_rc", 32'(report_cnt), 32'd1);
    drive_cycle(1'b1, 4'b1111, 1'b0);
    wait_deadlock(4'b1111, 10, n);
    check_val("en_resume_idx", 32'(deadlock_idx), 32'd2);

    // round robin with hold-off
    do_reset();
    for (int r = 0; r < 4; r++) begin
      wait_deadlock(4'b1001, 40, n);
      if (r > 0) check_val("rr_gap", 32'(n), 32'(HOLD + THR));
      check_val("rr_idx", 32'(deadlock_idx), 32'(exp_rr[r]));
      drive_cycle(1'b1, 4'b1001, 1'b0);
      drive_cycle(1'b1, 4'b1001, 1'b1);
    end

    // async reset in CONFIRM, then ack in SCAN ignored
    do_reset();
    drive_cycle(1'b1, 4'b0000, 1'b0);
    drive_cycle(1'b1, 4'b0001, 1'b0);
    drive_cycle(1'b1, 4'b0001, 1'b0);
    async_reset_pulse();
    drive_cycle(1'b1, 4'b0000, 1'b0);
    drive_cycle(1'b1, 4'b0000, 1'b1);
    check_val("ack_in_scan", 32'(busy), 32'd0);

    // randomized traffic
    pat = '0; pat_len = 0;
    for (int c = 0; c < 4000; c++) begin
      if (pat_len == 0) begin
        pat     = N'($urandom_range(0, (1 << N) - 1));
        pat_len = $urandom_range(1, 10);
      end
      pat_len--;
      if ($urandom_range(0, 499) == 0) async_reset_pulse();
      drive_cycle($urandom_range(0, 80) != 0, pat, $urandom_range(0, 3) == 0);
    end

    check_val("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
